// File: rtl/scrod_trig_responder.sv
// scrod_trig_responder: SCROD-side end of the MTC trigger link.
// Raises ACK from a masked local hit count, accepts the MTC's broadcast TRG,
// issues one START_READOUT per accepted trigger, then holds BUSY through
// readout and a fixed holdoff. Slow-control counters for accepted, expired
// and missed triggers.
// Optional feature: define SCROD_TRG_TIMESTAMP_EN to add a free-running
// 32-bit counter and the TRG_TIMESTAMP output latched on each START_READOUT.

module scrod_trig_responder #(
    parameter int unsigned N_HITS         = 8,
    parameter int unsigned ACK_LEN        = 16,
    parameter int unsigned HOLDOFF_CYCLES = 32
) (
    input  logic              CLK_80MHZ,
    input  logic              RESET,
    input  logic              TRG,
    output logic              ACK,
    input  logic [N_HITS-1:0] HIT,
    input  logic [N_HITS-1:0] HIT_MASK,
    input  logic [3:0]        MIN_HITS,
    output logic              START_READOUT,
    input  logic              READOUT_DONE,
    output logic              BUSY,
    output logic [31:0]       TRG_COUNT,
    output logic [15:0]       EXPIRED_COUNT,
`ifdef SCROD_TRG_TIMESTAMP_EN
    output logic [31:0]       TRG_TIMESTAMP,
`endif
    output logic [15:0]       MISSED_COUNT
);

    // Terminal values of the ACK window and holdoff counters.
    localparam logic [7:0] ACK_LAST  = 8'(ACK_LEN - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    // Spare encodings of the 3-bit state fall back to StIdle.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAckHold = 3'd1,
        StReadout = 3'd2,
        StHoldoff = 3'd3
    } state_t;

    state_t r_state, w_state_next;

    // TRG synchroniser and edge detect
    logic r_trg_sync1, r_trg_sync2, r_trg_sync2_d;
    logic w_trg_edge;

    // Hit path
    logic [N_HITS-1:0] r_hit;
    logic [N_HITS-1:0] w_hit_masked;
    logic [31:0]       w_hit_sum;
    logic [3:0]        w_hit_cnt;
    logic              w_local_req;

    // FSM counters and event strobes
    logic [7:0] r_ack_cnt, w_ack_cnt_next;
    logic [7:0] r_hold_cnt, w_hold_cnt_next;
    logic       w_enter_readout;
    logic       w_expire;
    logic       w_missed;

    // Registered outputs
    logic        r_ack;
    logic        r_start;
    logic [31:0] r_trg_count;
    logic [15:0] r_expired_count;
    logic [15:0] r_missed_count;

    // Synchronise TRG into the clock domain and register the hit word once.
    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            r_trg_sync1   <= 1'b0;
            r_trg_sync2   <= 1'b0;
            r_trg_sync2_d <= 1'b0;
            r_hit         <= '0;
        end else begin
            r_trg_sync1   <= TRG;
            r_trg_sync2   <= r_trg_sync1;
            r_trg_sync2_d <= r_trg_sync2;
            r_hit         <= HIT;
        end
    end

    assign w_trg_edge   = r_trg_sync2 & ~r_trg_sync2_d;
    assign w_hit_masked = r_hit & HIT_MASK;

    // Population count of the masked hits, clamped to the 4-bit range.
    always_comb begin
        w_hit_sum = '0;
        for (int i = 0; i < int'(N_HITS); i++) begin
            w_hit_sum = w_hit_sum + 32'(w_hit_masked[i]);
        end
        w_hit_cnt = (w_hit_sum > 32'd15) ? 4'd15 : w_hit_sum[3:0];
    end

    assign w_local_req = (MIN_HITS != 4'd0) && (w_hit_cnt >= MIN_HITS);

    // State register with window and holdoff counters.
    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_ack_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ack_cnt  <= w_ack_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next-state logic; TRG wins over a local request in the same cycle.
    always_comb begin
        w_state_next    = r_state;
        w_ack_cnt_next  = r_ack_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_enter_readout = 1'b0;
        w_expire        = 1'b0;
        w_missed        = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_trg_edge) begin
                    w_state_next    = StReadout;
                    w_enter_readout = 1'b1;
                end else if (w_local_req) begin
                    w_state_next   = StAckHold;
                    w_ack_cnt_next = '0;
                end
            end
            StAckHold: begin
                if (w_trg_edge) begin
                    w_state_next    = StReadout;
                    w_enter_readout = 1'b1;
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_state_next = StIdle;
                    w_expire     = 1'b1;
                end else begin
                    w_ack_cnt_next = r_ack_cnt + 8'd1;
                end
            end
            StReadout: begin
                w_missed = w_trg_edge;
                if (READOUT_DONE) begin
                    w_state_next    = StHoldoff;
                    w_hold_cnt_next = '0;
                end
            end
            StHoldoff: begin
                w_missed = w_trg_edge;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = StIdle;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output strobes and slow-control counters, updated with the state.
    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            r_ack           <= 1'b0;
            r_start         <= 1'b0;
            r_trg_count     <= '0;
            r_expired_count <= '0;
            r_missed_count  <= '0;
        end else begin
            r_ack   <= (w_state_next == StAckHold);
            r_start <= w_enter_readout;
            if (w_enter_readout) begin
                r_trg_count <= r_trg_count + 32'd1;
            end
            if (w_expire && (r_expired_count != 16'hFFFF)) begin
                r_expired_count <= r_expired_count + 16'd1;
            end
            if (w_missed && (r_missed_count != 16'hFFFF)) begin
                r_missed_count <= r_missed_count + 16'd1;
            end
        end
    end

`ifdef SCROD_TRG_TIMESTAMP_EN
    logic [31:0] r_free_cnt;
    logic [31:0] r_trg_ts;

    // Free-running time base; the latch takes the value it will hold in the
    // START_READOUT cycle.
    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            r_free_cnt <= '0;
            r_trg_ts   <= '0;
        end else begin
            r_free_cnt <= r_free_cnt + 32'd1;
            if (w_enter_readout) begin
                r_trg_ts <= r_free_cnt + 32'd1;
            end
        end
    end

    assign TRG_TIMESTAMP = r_trg_ts;
`endif

    assign ACK           = r_ack;
    assign START_READOUT = r_start;
    assign BUSY          = (r_state == StReadout) || (r_state == StHoldoff);
    assign TRG_COUNT     = r_trg_count;
    assign EXPIRED_COUNT = r_expired_count;
    assign MISSED_COUNT  = r_missed_count;

endmodule

// File: tb/tb_scrod_trig_responder.sv
// tb_scrod_trig_responder: self-checking bench for scrod_trig_responder.
// Expected START_READOUT cycles and TRG_COUNT values are queued when TRG is
// driven and compared by a monitor when the pulse appears.

module tb_scrod_trig_responder;

    logic        CLK_80MHZ;
    logic        RESET;
    logic        TRG;
    logic        ACK;
    logic [7:0]  HIT;
    logic [7:0]  HIT_MASK;
    logic [3:0]  MIN_HITS;
    logic        START_READOUT;
    logic        READOUT_DONE;
    logic        BUSY;
    logic [31:0] TRG_COUNT;
    logic [15:0] EXPIRED_COUNT;
    logic [15:0] MISSED_COUNT;
`ifdef SCROD_TRG_TIMESTAMP_EN
    logic [31:0] TRG_TIMESTAMP;
`endif

    scrod_trig_responder #(
        .N_HITS        (8),
        .ACK_LEN       (16),
        .HOLDOFF_CYCLES(32)
    ) u_dut (
        .CLK_80MHZ    (CLK_80MHZ),
        .RESET        (RESET),
        .TRG          (TRG),
        .ACK          (ACK),
        .HIT          (HIT),
        .HIT_MASK     (HIT_MASK),
        .MIN_HITS     (MIN_HITS),
        .START_READOUT(START_READOUT),
        .READOUT_DONE (READOUT_DONE),
        .BUSY         (BUSY),
        .TRG_COUNT    (TRG_COUNT),
        .EXPIRED_COUNT(EXPIRED_COUNT),
`ifdef SCROD_TRG_TIMESTAMP_EN
        .TRG_TIMESTAMP(TRG_TIMESTAMP),
`endif
        .MISSED_COUNT (MISSED_COUNT)
    );

    initial CLK_80MHZ = 1'b0;
    always #6 CLK_80MHZ = ~CLK_80MHZ;

    int cyc = 0;
    always @(posedge CLK_80MHZ) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] mask;
        logic [7:0] hit;
        logic [3:0] min;
        logic       ack;
    } hit_vec_t;

    hit_vec_t vecs [5] = '{
        '{8'hFF, 8'h03, 4'd2, 1'b1},
        '{8'h0F, 8'hF1, 4'd2, 1'b0},
        '{8'hF0, 8'h3F, 4'd2, 1'b1},
        '{8'hFF, 8'hFF, 4'd9, 1'b0},
        '{8'hFF, 8'hFF, 4'd8, 1'b1}
    };

    logic [31:0] exp_trg     = '0;
    logic [15:0] exp_expired = '0;
    logic        start_prev  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK_80MHZ);
        #1;
    endtask

    // Queue an expected trigger for a TRG rising edge driven this cycle.
    task automatic push_trigger();
        sb_t e;
        exp_trg  = exp_trg + 32'd1;
        e.cyc    = cyc + 3;
        e.cnt    = exp_trg;
        sb_q.push_back(e);
    endtask

    // Monitor: every START_READOUT pulse must match a queued expectation.
    always @(negedge CLK_80MHZ) begin
        if (start_prev) begin
            check_val("start_width", 32'(START_READOUT), 32'd0);
        end
        if (START_READOUT) begin
            n_starts++;
            if (sb_q.size() == 0) begin
                check_val("start_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check_val("start_cycle", 32'(cyc), 32'(e.cyc));
                check_val("start_trg_count", TRG_COUNT, e.cnt);
            end
        end
        start_prev = START_READOUT;
    end

    initial begin
        int n;
        int t;
        int c0;
        RESET        = 1'b1;
        TRG          = 1'b0;
        HIT          = '0;
        HIT_MASK     = 8'hFF;
        MIN_HITS     = 4'd2;
        READOUT_DONE = 1'b0;
        repeat (3) tick();
        check_val("rst_ack", 32'(ACK), 32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_start", 32'(START_READOUT), 32'd0);
        check_val("rst_trg_count", TRG_COUNT, 32'd0);
        check_val("rst_expired", 32'(EXPIRED_COUNT), 32'd0);
        check_val("rst_missed", 32'(MISSED_COUNT), 32'd0);
        RESET = 1'b0;
        tick();

        // Local requests with no TRG: each must expire after 16 ACK cycles.
        foreach (vecs[i]) begin
            HIT_MASK = vecs[i].mask;
            MIN_HITS = vecs[i].min;
            HIT      = vecs[i].hit;
            tick();
            HIT = '0;
            tick();
            check_val("ack_rise", 32'(ACK), 32'(vecs[i].ack));
            n = int'(ACK);
            repeat (20) begin
                tick();
                n += int'(ACK);
            end
            check_val("ack_len", 32'(n), vecs[i].ack ? 32'd16 : 32'd0);
            if (vecs[i].ack) exp_expired = exp_expired + 16'd1;
            check_val("expired_count", 32'(EXPIRED_COUNT), 32'(exp_expired));
        end
        check_val("no_trg_count", TRG_COUNT, 32'd0);
        check_val("no_start", 32'(n_starts), 32'd0);

        // Request answered by TRG 5 cycles after ACK rises.
        HIT_MASK = 8'hFF;
        MIN_HITS = 4'd2;
        HIT      = 8'h03;
        tick();
        HIT = '0;
        tick();
        check_val("ack_up", 32'(ACK), 32'd1);
        repeat (5) tick();
        TRG = 1'b1;
        push_trigger();
        tick();
        tick();
        check_val("ack_before_trg", 32'(ACK), 32'd1);
        tick();
        check_val("ack_drop", 32'(ACK), 32'd0);
        check_val("busy_readout", 32'(BUSY), 32'd1);
        check_val("start_now", 32'(START_READOUT), 32'd1);
        repeat (5) tick();
        TRG = 1'b0;

        // Second TRG during READOUT is counted as missed.
        repeat (4) tick();
        TRG = 1'b1;
        repeat (8) tick();
        TRG = 1'b0;
        repeat (4) tick();
        check_val("missed_count", 32'(MISSED_COUNT), 32'd1);
        check_val("busy_still", 32'(BUSY), 32'd1);
        check_val("trg_count_1", TRG_COUNT, exp_trg);
        check_val("expired_kept", 32'(EXPIRED_COUNT), 32'(exp_expired));

        // Holdoff after READOUT_DONE lasts exactly 32 cycles.
        READOUT_DONE = 1'b1;
        tick();
        READOUT_DONE = 1'b0;
        n = 0;
        repeat (40) begin
            n += int'(BUSY);
            tick();
        end
        check_val("holdoff_len", 32'(n), 32'd32);

        // Local requests disabled; TRG in IDLE still triggers.
        MIN_HITS = 4'd0;
        HIT      = 8'hFF;
        n = 0;
        repeat (6) begin
            tick();
            n += int'(ACK);
        end
        check_val("min0_no_ack", 32'(n), 32'd0);
        TRG = 1'b1;
        push_trigger();
        t = cyc;
        repeat (3) tick();
        READOUT_DONE = 1'b1;  // same cycle as START_READOUT
        repeat (5) tick();
        TRG = 1'b0;
        while (cyc < t + 35) tick();
        check_val("holdoff_last", 32'(BUSY), 32'd1);
        tick();
        check_val("holdoff_end", 32'(BUSY), 32'd0);
        check_val("trg_count_2", TRG_COUNT, exp_trg);
        check_val("ack_min0", 32'(ACK), 32'd0);
        READOUT_DONE = 1'b0;
        HIT          = '0;
        MIN_HITS     = 4'd2;
        tick();

        // Reset during ACK_HOLD.
        HIT = 8'h03;
        tick();
        HIT = '0;
        tick();
        tick();
        check_val("ack_pre_rst", 32'(ACK), 32'd1);
        RESET = 1'b1;
        tick();
        check_val("rst_ackhold_ack", 32'(ACK), 32'd0);
        check_val("rst_ackhold_busy", 32'(BUSY), 32'd0);
        check_val("rst_ackhold_trg", TRG_COUNT, 32'd0);
        check_val("rst_ackhold_exp", 32'(EXPIRED_COUNT), 32'd0);
        check_val("rst_ackhold_miss", 32'(MISSED_COUNT), 32'd0);
        RESET       = 1'b0;
        exp_trg     = '0;
        exp_expired = '0;
        tick();

        // Reset during READOUT.
        TRG = 1'b1;
        push_trigger();
        repeat (8) tick();
        TRG = 1'b0;
        check_val("busy_pre_rst", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        tick();
        check_val("rst_readout_busy", 32'(BUSY), 32'd0);
        check_val("rst_readout_ack", 32'(ACK), 32'd0);
        check_val("rst_readout_trg", TRG_COUNT, 32'd0);
        RESET   = 1'b0;
        exp_trg = '0;
        tick();

        // TRG edge in the synchroniser when reset hits: no trigger.
        n = n_starts;
        TRG = 1'b1;
        tick();
        RESET = 1'b1;
        repeat (7) tick();
        TRG = 1'b0;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (10) tick();
        check_val("inflight_start", 32'(n_starts), 32'(n));
        check_val("inflight_trg", TRG_COUNT, 32'd0);
        check_val("inflight_busy", 32'(BUSY), 32'd0);

`ifdef SCROD_TRG_TIMESTAMP_EN
        RESET = 1'b1;
        tick();
        RESET   = 1'b0;
        exp_trg = '0;
        c0      = cyc;
        check_val("ts_reset", TRG_TIMESTAMP, 32'd0);
        while (cyc < c0 + 100) tick();
        TRG = 1'b1;
        push_trigger();
        repeat (3) tick();
        check_val("ts_latch", TRG_TIMESTAMP, 32'd103);
        repeat (5) tick();
        TRG = 1'b0;
        repeat (20) tick();
        check_val("ts_hold", TRG_TIMESTAMP, 32'd103);
`else
        c0 = 0;
`endif

        repeat (5) tick();
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
